fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 37 +++
 rtl/fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if -- bus bundle between the fetch controller, instruction
// memory and the downstream consumer.
//
// Signals (direction as seen from the fetch controller, modport master):
//   imem_req_o     out  instruction-memory request
//   imem_addr_o    out  fetch address
//   imem_ack_i     in   memory acknowledge, imem_rdata_i valid same cycle
//   imem_rdata_i   in   returned instruction word
//   instr_valid_o  out  held instruction valid for downstream
//   instr_ready_i  in   downstream accept
//   instr_o        out  held instruction
//   instr_pc_o     out  address of instr_o
// The slave modport is the memory/consumer side of the same wires.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             imem_req_o;
   logic [WIDTH-1:0] imem_addr_o;
   logic             imem_ack_i;
   logic [WIDTH-1:0] imem_rdata_i;
   logic             instr_valid_o;
   logic             instr_ready_i;
   logic [WIDTH-1:0] instr_o;
   logic [WIDTH-1:0] instr_pc_o;

   modport master (
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      input  imem_ack_i, imem_rdata_i, instr_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      output imem_ack_i, imem_rdata_i, instr_ready_i
   );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- single-outstanding instruction fetch controller.
//
// Issues one instruction-memory request at a time, holds the returned word
// in a one-entry output buffer until downstream accepts it, and handles
// branch redirects arriving while idle, while a request is outstanding, or
// while the buffer is full.
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous reset, active low
//   branch_i         in   redirect request
//   branch_target_i  in   redirect address (WIDTH)
//   bus              fetch_ctrl_if.master (memory + downstream handshake)
//   misalign_o       out  sticky misaligned-redirect flag (only when
//                         FETCH_ALIGN_CHECK_EN is defined)
//
// Configuration macro FETCH_ALIGN_CHECK_EN:
//   defined   -> redirects with target[1:0]!=0 are ignored and flagged
//   undefined -> target[1:0] is forced to zero on every redirect
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             branch_i,
   input  logic [WIDTH-1:0] branch_target_i,
   fetch_ctrl_if.master     bus
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic             misalign_o
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] redir_q, redir_d;
   logic             redir_pend_q, redir_pend_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
   logic             instr_valid_q, instr_valid_d;

   // Qualified redirect: br_take says the redirect is acted on, br_tgt is
   // the address it goes to.
   logic             br_take;
   logic [WIDTH-1:0] br_tgt;

   function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
      return a & ~WIDTH'(3);
   endfunction

`ifdef FETCH_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;
   logic br_misaligned;

   assign br_misaligned = branch_i && (branch_target_i[1:0] != 2'b00);
   assign br_take       = branch_i && !br_misaligned;
   assign br_tgt        = branch_target_i;
   assign misalign_o    = misalign_q;

   always_comb begin
      misalign_d = misalign_q | br_misaligned;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) misalign_q <= 1'b0;
      else      misalign_q <= misalign_d;
   end
`else
   assign br_take = branch_i;
   assign br_tgt  = word_align(branch_target_i);
`endif

   // State and datapath registers; an ack seen while rst is low is ignored
   // because the reset branch dominates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         redir_q       <= '0;
         redir_pend_q  <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         redir_q       <= redir_d;
         redir_pend_q  <= redir_pend_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // Next-state logic. An ack that coincides with a redirect (live or
   // latched) keeps the FSM in FETCH so the refetch starts immediately.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   if (bus.imem_ack_i && !br_take && !redir_pend_q) state_d = FULL;
         FULL:    if (br_take || bus.instr_ready_i) state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values. pc only moves on an ack or outside FETCH, so the
   // request address stays stable while a request is outstanding.
   always_comb begin
      pc_d          = pc_q;
      redir_d       = redir_q;
      redir_pend_d  = redir_pend_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      unique case (state_q)
         IDLE: begin
            if (br_take) pc_d = br_tgt;
         end
         FETCH: begin
            if (bus.imem_ack_i) begin
               if (br_take) begin
                  // Live branch beats the latched target.
                  pc_d         = br_tgt;
                  redir_pend_d = 1'b0;
               end else if (redir_pend_q) begin
                  pc_d         = redir_q;
                  redir_pend_d = 1'b0;
               end else begin
                  instr_d       = bus.imem_rdata_i;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  pc_d          = pc_q + WIDTH'(4);
               end
            end else if (br_take) begin
               redir_d      = br_tgt;
               redir_pend_d = 1'b1;
            end
         end
         FULL: begin
            if (br_take) begin
               instr_valid_d = 1'b0;
               pc_d          = br_tgt;
            end else if (bus.instr_ready_i) begin
               instr_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      bus.imem_req_o    = (state_q == FETCH);
      bus.imem_addr_o   = pc_q;
      bus.instr_valid_o = instr_valid_q;
      bus.instr_o       = instr_q;
      bus.instr_pc_o    = instr_pc_q;
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- directed bench for fetch_ctrl.
// dut0 uses RESET_PC=0 and carries most scenarios; dut1 uses
// RESET_PC=0xFFFFFFFC for the address wrap and reset-restart cases.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        br0, br1;
   logic [31:0] tgt0, tgt1;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   fetch_ctrl_if #(.WIDTH(32)) bus0 ();
   fetch_ctrl_if #(.WIDTH(32)) bus1 ();

`ifdef FETCH_ALIGN_CHECK_EN
   logic mis0, mis1;
`endif

   fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut0 (
      .clk             (clk),
      .rst             (rst),
      .branch_i        (br0),
      .branch_target_i (tgt0),
      .bus             (bus0.master)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .misalign_o      (mis0)
`endif
   );

   fetch_ctrl #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk             (clk),
      .rst             (rst),
      .branch_i        (br1),
      .branch_target_i (tgt1),
      .bus             (bus1.master)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .misalign_o      (mis1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      br0  = 1'b0; tgt0 = '0;
      br1  = 1'b0; tgt1 = '0;
      bus0.imem_ack_i = 1'b0; bus0.imem_rdata_i = '0; bus0.instr_ready_i = 1'b0;
      bus1.imem_ack_i = 1'b0; bus1.imem_rdata_i = '0; bus1.instr_ready_i = 1'b0;

      // Reset state
      #1 rst = 1'b0;
      #1;
      chk("rst_req",   32'(bus0.imem_req_o), 32'd0);
      chk("rst_valid", 32'(bus0.instr_valid_o), 32'd0);
      chk("rst_instr", bus0.instr_o, 32'd0);
      chk("rst_ipc",   bus0.instr_pc_o, 32'd0);
      chk("rst_pc1",   bus1.imem_addr_o, 32'hFFFF_FFFC);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("rst_mis",   32'(mis0), 32'd0);
`endif
      tick;
      tick;
      rst = 1'b1;
      bus1.imem_ack_i    = 1'b1;
      bus1.instr_ready_i = 1'b1;
      bus1.imem_rdata_i  = 32'h5555_0000;

      // Sequential fetch, ack on first cycle, ready=1
      tick;
      chk("seq0_req",  32'(bus0.imem_req_o), 32'd1);
      chk("seq0_addr", bus0.imem_addr_o, 32'h0);
      chk("wrap_a0",   bus1.imem_addr_o, 32'hFFFF_FFFC);
      bus0.imem_ack_i = 1'b1; bus0.imem_rdata_i = 32'hA0; bus0.instr_ready_i = 1'b1;
      tick;
      chk("seq0_valid", 32'(bus0.instr_valid_o), 32'd1);
      chk("seq0_instr", bus0.instr_o, 32'hA0);
      chk("seq0_ipc",   bus0.instr_pc_o, 32'h0);
      chk("seq0_noreq", 32'(bus0.imem_req_o), 32'd0);
      chk("wrap_ipc",   bus1.instr_pc_o, 32'hFFFF_FFFC);
      bus0.imem_ack_i = 1'b0;
      tick;
      chk("seq1_addr",  bus0.imem_addr_o, 32'h4);
      chk("seq1_valid", 32'(bus0.instr_valid_o), 32'd0);
      chk("wrap_a1",    bus1.imem_addr_o, 32'h0);
      chk("wrap_req1",  32'(bus1.imem_req_o), 32'd1);
      bus1.imem_ack_i = 1'b0;
      bus0.imem_ack_i = 1'b1; bus0.imem_rdata_i = 32'hA1;
      tick;
      chk("seq1_ipc",   bus0.instr_pc_o, 32'h4);
      chk("seq1_instr", bus0.instr_o, 32'hA1);
      bus0.imem_ack_i = 1'b0;
      tick;
      chk("seq2_addr",  bus0.imem_addr_o, 32'h8);

      // Backpressure on the instruction fetched at 0x8
      bus0.imem_ack_i = 1'b1; bus0.imem_rdata_i = 32'hA2; bus0.instr_ready_i = 1'b0;
      tick;
      chk("bp_ipc", bus0.instr_pc_o, 32'h8);
      bus0.imem_ack_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("bp_valid", 32'(bus0.instr_valid_o), 32'd1);
         chk("bp_instr", bus0.instr_o, 32'hA2);
         chk("bp_noreq", 32'(bus0.imem_req_o), 32'd0);
      end
      bus0.instr_ready_i = 1'b1;
      tick;
      chk("bp_rel_req",  32'(bus0.imem_req_o), 32'd1);
      chk("bp_rel_addr", bus0.imem_addr_o, 32'hC);

      // Branch during an outstanding request, ack two cycles later
      tick;
      chk("hold_addr", bus0.imem_addr_o, 32'hC);
      br0 = 1'b1; tgt0 = 32'h100;
      tick;
      br0 = 1'b0;
      chk("brw_addr_stable", bus0.imem_addr_o, 32'hC);
      chk("brw_req_stable",  32'(bus0.imem_req_o), 32'd1);
      tick;
      chk("brw_addr_stable2", bus0.imem_addr_o, 32'hC);
      bus0.imem_ack_i = 1'b1; bus0.imem_rdata_i = 32'hDEAD;
      tick;
      bus0.imem_ack_i = 1'b0;
      chk("brw_valid", 32'(bus0.instr_valid_o), 32'd0);
      chk("brw_req",   32'(bus0.imem_req_o), 32'd1);
      chk("brw_addr",  bus0.imem_addr_o, 32'h100);

      // Live branch coinciding with a latched one at ack
      br0 = 1'b1; tgt0 = 32'h200;
      tick;
      br0 = 1'b0;
      chk("coin_hold", bus0.imem_addr_o, 32'h100);
      bus0.imem_ack_i = 1'b1; br0 = 1'b1; tgt0 = 32'h300;
      tick;
      br0 = 1'b0;
      chk("coin_addr",  bus0.imem_addr_o, 32'h300);
      chk("coin_valid", 32'(bus0.instr_valid_o), 32'd0);

      // Branch in FULL together with ready
      bus0.imem_rdata_i = 32'hB0;
      tick;
      chk("full_valid", 32'(bus0.instr_valid_o), 32'd1);
      chk("full_ipc",   bus0.instr_pc_o, 32'h300);
      bus0.imem_ack_i = 1'b0; bus0.instr_ready_i = 1'b1; br0 = 1'b1; tgt0 = 32'h40;
      tick;
      br0 = 1'b0;
      chk("fullbr_valid", 32'(bus0.instr_valid_o), 32'd0);
      chk("fullbr_addr",  bus0.imem_addr_o, 32'h40);
      chk("fullbr_req",   32'(bus0.imem_req_o), 32'd1);

      // Misaligned redirect target
      br0 = 1'b1; tgt0 = 32'h102;
      tick;
      br0 = 1'b0;
      bus0.imem_ack_i = 1'b1; bus0.imem_rdata_i = 32'hC0;
      tick;
      bus0.imem_ack_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_flag",  32'(mis0), 32'd1);
      chk("mis_valid", 32'(bus0.instr_valid_o), 32'd1);
      chk("mis_ipc",   bus0.instr_pc_o, 32'h40);
      tick;
      chk("mis_seq",   bus0.imem_addr_o, 32'h44);
      chk("mis_stick", 32'(mis0), 32'd1);
`else
      chk("algn_valid", 32'(bus0.instr_valid_o), 32'd0);
      chk("algn_addr",  bus0.imem_addr_o, 32'h100);
`endif

      // Reset asserted mid-request, with an ack arriving during reset
      chk("mid_req_pre", 32'(bus0.imem_req_o), 32'd1);
      bus0.imem_ack_i = 1'b1; bus0.imem_rdata_i = 32'hEE;
      rst = 1'b0;
      #1;
      chk("mid_req_now",   32'(bus0.imem_req_o), 32'd0);
      chk("mid_addr_now",  bus0.imem_addr_o, 32'h0);
      tick;
      chk("mid_req",   32'(bus0.imem_req_o), 32'd0);
      chk("mid_valid", 32'(bus0.instr_valid_o), 32'd0);
      chk("mid_instr", bus0.instr_o, 32'd0);
      chk("mid_ipc",   bus0.instr_pc_o, 32'd0);
      bus0.imem_ack_i = 1'b0;
      rst = 1'b1;
      tick;
      chk("restart_addr0", bus0.imem_addr_o, 32'h0);
      chk("restart_req0",  32'(bus0.imem_req_o), 32'd1);
      chk("restart_addr1", bus1.imem_addr_o, 32'hFFFF_FFFC);

      // Branch while IDLE right after reset release
      rst = 1'b0;
      #1 rst = 1'b1;
      br0 = 1'b1; tgt0 = 32'h80;
      tick;
      br0 = 1'b0;
      chk("idle_br_addr", bus0.imem_addr_o, 32'h80);
      chk("idle_br_req",  32'(bus0.imem_req_o), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
